// File: rtl/colune_pkg.sv
// colune_pkg: shared scan-state type, default geometry and column helpers for the matrix scanner
package colune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_e;

    localparam int COLUNE_SIZE_DEF   = 7;
    localparam int TOTAL_COLUNES_DEF = 4;

    // Wide enough to be truncated to any practical row count.
    localparam logic [63:0] ROW_OFF = '1;

    function automatic int col_offset(input int k, input int size);
        return k * size;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter whose terminal count marks the end of a blank or dwell period
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and rest at zero.
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = cnt_q == '0;

endmodule

// File: rtl/colune_matrix_scanner.sv
// colune_matrix_scanner: double-buffered frame intake and blanked column multiplexing of an LED matrix
module colune_matrix_scanner
    import colune_pkg::*;
#(
    parameter int COLUNE_SIZE   = COLUNE_SIZE_DEF,
    parameter int TOTAL_COLUNES = TOTAL_COLUNES_DEF,
    parameter int DATA_WIDTH    = 28,
    parameter int DWELL_CYCLES  = 50000,
    parameter int BLANK_CYCLES  = 500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    frame_data,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic                     enable,
    output logic [COLUNE_SIZE-1:0]   row_out,
    output logic [TOTAL_COLUNES-1:0] col_sel,
    output logic                     frame_done
);

    localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
    localparam int IW = TOTAL_COLUNES > 1 ? $clog2(TOTAL_COLUNES) : 1;
    localparam logic [IW-1:0]          LAST_COL   = IW'(TOTAL_COLUNES - 1);
    localparam logic [CW-1:0]          BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]          DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [COLUNE_SIZE-1:0] ALL_OFF    = COLUNE_SIZE'(ROW_OFF);

    scan_state_e              state_q, state_d;
    logic [IW-1:0]            col_q, col_d;
    logic [DATA_WIDTH-1:0]    active_q, active_d;
    logic [DATA_WIDTH-1:0]    shadow_q, shadow_d;
    logic                     active_valid_q, active_valid_d;
    logic                     shadow_full_q, shadow_full_d;
    logic                     frame_ready_q, frame_ready_d;
    logic                     frame_done_q, frame_done_d;
    logic [COLUNE_SIZE-1:0]   row_out_q, row_out_d;
    logic [TOTAL_COLUNES-1:0] col_sel_q, col_sel_d;
    logic                     tmr_load, tmr_tc, swap;
    logic [CW-1:0]            tmr_val;

    scan_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Next state, buffer handshake and the values the output registers take on the next edge.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        frame_done_d   = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        swap           = 1'b0;
        if (frame_valid && frame_ready_q) begin
            shadow_d      = frame_data;
            shadow_full_d = 1'b1;
        end
        if (!enable) begin
            state_d  = ST_IDLE;
            col_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (shadow_full_q || active_valid_q) begin
                    swap     = shadow_full_q;
                    state_d  = ST_BLANK;
                    col_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = BLANK_LOAD;
                end
                ST_BLANK: if (tmr_tc) begin
                    state_d  = ST_SHOW;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LOAD;
                end
                ST_SHOW: if (tmr_tc) begin
                    state_d      = ST_BLANK;
                    tmr_load     = 1'b1;
                    tmr_val      = BLANK_LOAD;
                    frame_done_d = col_q == LAST_COL;
                    swap         = col_q == LAST_COL && shadow_full_q;
                    col_d        = col_q == LAST_COL ? '0 : col_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // A swap only ever sees a full shadow, which blocks a same-edge accept.
        if (swap) begin
            active_d       = shadow_q;
            active_valid_d = 1'b1;
            shadow_full_d  = 1'b0;
        end
        frame_ready_d = !shadow_full_d;
        row_out_d     = state_d == ST_SHOW ? COLUNE_SIZE'(active_d >> col_offset(int'(col_d), COLUNE_SIZE)) : ALL_OFF;
        col_sel_d     = state_d == ST_SHOW ? ~(TOTAL_COLUNES'(1) << col_d) : '1;
    end

    // State, frame buffers and outputs; reset drops both frames and leaves the matrix dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            col_q          <= '0;
            active_q       <= '0;
            shadow_q       <= '0;
            active_valid_q <= 1'b0;
            shadow_full_q  <= 1'b0;
            frame_ready_q  <= 1'b1;
            frame_done_q   <= 1'b0;
            row_out_q      <= ALL_OFF;
            col_sel_q      <= '1;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            active_q       <= active_d;
            shadow_q       <= shadow_d;
            active_valid_q <= active_valid_d;
            shadow_full_q  <= shadow_full_d;
            frame_ready_q  <= frame_ready_d;
            frame_done_q   <= frame_done_d;
            row_out_q      <= row_out_d;
            col_sel_q      <= col_sel_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign frame_done  = frame_done_q;
    assign row_out     = row_out_q;
    assign col_sel     = col_sel_q;

endmodule

// File: tb/tb_colune_matrix_scanner.sv
// tb_colune_matrix_scanner: directed checks of scan timing, buffering, enable and reset behaviour
module tb_colune_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_valid = 1'b0;
    logic        enable = 1'b1;
    logic [27:0] frame_data = '0;
    logic        frame_ready, frame_done;
    logic [6:0]  row_out;
    logic [3:0]  col_sel;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc_n = 0;

    localparam logic [27:0] F1 = 28'h0FF_FFFE;
    localparam logic [27:0] FA = {7'h08, 7'h04, 7'h02, 7'h01};
    localparam logic [27:0] FB = {7'h4C, 7'h33, 7'h2A, 7'h55};
    localparam logic [27:0] FC = 28'h000_0000;
    localparam logic [27:0] FD = {7'h11, 7'h22, 7'h44, 7'h0F};

    always #5 clk = ~clk;

    colune_matrix_scanner #(
        .COLUNE_SIZE   (7),
        .TOTAL_COLUNES (4),
        .DATA_WIDTH    (28),
        .DWELL_CYCLES  (4),
        .BLANK_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .enable      (enable),
        .row_out     (row_out),
        .col_sel     (col_sel),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic expect_out(input logic [6:0] r, input logic [3:0] c, input logic d, input logic rdy);
        check("row_out", 32'(row_out), 32'(r));
        check("col_sel", 32'(col_sel), 32'(c));
        check("frame_done", 32'(frame_done), 32'(d));
        check("frame_ready", 32'(frame_ready), 32'(rdy));
    endtask

    task automatic cyc(input logic [6:0] r, input logic [3:0] c, input logic d, input logic rdy);
        expect_out(r, c, d, rdy);
        step();
    endtask

    // Cycles [from,to) of a 24-cycle frame: per column 2 blank cycles then 4 lit cycles.
    task automatic frame_part(input logic [27:0] f, input logic d, input logic rdy, input int from, input int to);
        for (int i = from; i < to; i++) begin
            int k = i / 6;
            logic [27:0] t = f >> (7 * k);
            if (i % 6 < 2) cyc(7'h7F, 4'hF, d && i == 0, rdy);
            else           cyc(t[6:0], 4'hF ^ (4'h1 << k), 1'b0, rdy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        expect_out(7'h7F, 4'hF, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic load_frame(input logic [27:0] f);
        frame_data = f;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        expect_out(7'h7F, 4'hF, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        // Reset state, then first frame: accept, 2 dark cycles, column 0 lit for 4.
        do_reset();
        load_frame(F1);
        frame_part(F1, 1'b0, 1'b1, 0, 8);

        // Full frame walk and identical refresh.
        do_reset();
        load_frame(FA);
        frame_part(FA, 1'b0, 1'b1, 0, 24);
        frame_part(FA, 1'b1, 1'b1, 0, 24);

        // Second frame buffered mid-frame, third held off, swap at boundary.
        frame_part(FA, 1'b1, 1'b1, 0, 6);
        frame_data = FB;
        frame_valid = 1'b1;
        frame_part(FA, 1'b1, 1'b1, 6, 7);
        frame_data = FC;
        frame_part(FA, 1'b1, 1'b0, 7, 24);
        frame_valid = 1'b0;
        frame_part(FB, 1'b1, 1'b1, 0, 24);

        // Accept on the boundary edge with empty shadow: current frame repeats once.
        frame_part(FB, 1'b1, 1'b1, 0, 23);
        frame_data = FD;
        frame_valid = 1'b1;
        frame_part(FB, 1'b1, 1'b1, 23, 24);
        frame_valid = 1'b0;
        frame_part(FB, 1'b1, 1'b0, 0, 24);
        frame_part(FD, 1'b1, 1'b1, 0, 15);

        // Enable dropped during column 2, then restored.
        enable = 1'b0;
        frame_part(FD, 1'b1, 1'b1, 15, 16);
        repeat (3) cyc(7'h7F, 4'hF, 1'b0, 1'b1);
        enable = 1'b1;
        cyc(7'h7F, 4'hF, 1'b0, 1'b1);
        frame_part(FD, 1'b0, 1'b1, 0, 8);

        // Asynchronous reset while column 1 is lit.
        expect_out(7'h44, 4'hD, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(7'h7F, 4'hF, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;
        step();
        repeat (8) cyc(7'h7F, 4'hF, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/colune_matrix_scanner.md
Name: colune_matrix_scanner

Overview:
- Drives the physical LED matrix from a frame of TOTAL_COLUNES column patterns, each COLUNE_SIZE bits in the colune_display_decoder output format (1 = LED off).
- Accepts frames through a valid/ready handshake into a one-deep shadow buffer.
- Time-multiplexes columns with a dwell period per column and a blanking gap between columns to prevent ghosting.
- Sits between the per-column decoders and the matrix pins.

Parameters:
- COLUNE_SIZE, 7, rows per column (bits per column pattern).
- TOTAL_COLUNES, 4, columns per frame.
- DATA_WIDTH, 28, frame width; must equal COLUNE_SIZE*TOTAL_COLUNES.
- DWELL_CYCLES, 50000, clk cycles each column is driven (>=1).
- BLANK_CYCLES, 500, clk cycles all-off before each column (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_data  in  DATA_WIDTH  column k is bits [k*COLUNE_SIZE +: COLUNE_SIZE]; bit 0 = row A; 1 = off.
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  shadow buffer empty; transfer occurs when valid&ready at a clk edge.
- enable  in  1  scan enable; low forces all outputs off.
- row_out  out  COLUNE_SIZE  row drive, active-low (1 = off).
- col_sel  out  TOTAL_COLUNES  one-hot active-low column strobe.
- frame_done  out  1  one-cycle pulse at the end of the last column's dwell.

Behaviour:
- Reset: asynchronous and active-low; one clock domain.
  - Outputs: row_out all 1, col_sel all 1, frame_ready=1, frame_done=0.
  - State: IDLE, shadow empty, active_valid=0, column index 0, counter 0.
- Registers:
  - active frame plus active_valid flag.
  - shadow frame plus shadow_full flag.
  - column index 0..TOTAL_COLUNES-1.
  - dwell/blank counter, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1).
- Handshake:
  - frame_ready = !shadow_full, registered.
  - An accept sets shadow_full on the next edge; frame_ready drops the cycle after the accept.
  - Data held in the shadow is never overwritten.
- States: IDLE, BLANK, SHOW. All outputs are registered; row_out and col_sel change only on state/column transitions.
- IDLE:
  - Outputs all off.
  - Exit when shadow_full && enable: shadow -> active, active_valid=1, shadow_full=0, column 0, enter BLANK.
  - If active_valid && enable, enter BLANK at column 0 with no swap.
- BLANK:
  - row_out and col_sel all 1 for exactly BLANK_CYCLES cycles, then SHOW.
- SHOW:
  - col_sel[k]=0 (others 1), row_out = active column k, for exactly DWELL_CYCLES cycles.
  - If k < last: k+1, enter BLANK.
  - If k = last: pulse frame_done; k=0; if shadow_full, swap shadow -> active (same edge, frame_ready rises next cycle); enter BLANK.
- Continuous refresh: the active frame is redisplayed indefinitely until a new frame is swapped in. Swaps occur only at frame boundaries, so a displayed frame never mixes two inputs.
- Frame period = TOTAL_COLUNES*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Accept and boundary in the same cycle with the shadow empty: the frame lands in the shadow and is swapped at the next boundary (no bypass).
- enable low in any state:
  - Next edge: IDLE, outputs all off, counter cleared.
  - Active and shadow frames retained; handshake keeps operating.
  - No frame_done for an aborted frame.
  - When enable rises again, scanning restarts at BLANK column 0.
- Reset mid-scan discards both frames immediately, with no glitch to a lit state.

Decomposition:
- Package colune_pkg:
  - scan state enum (IDLE/BLANK/SHOW).
  - default COLUNE_SIZE/TOTAL_COLUNES constants.
  - ROW_OFF all-ones constant.
  - function for the column slice offset.
- Sub-module scan_timer: loadable down-counter with a terminal-count pulse, shared by BLANK and SHOW.

Test Plan:
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.
1. Reset, then frame_data=28'h0FF_FFFE held valid.
   - Accepted in the first cycle; frame_ready low for one cycle, then high.
   - 2 cycles all off, then col_sel=4'b1110 and row_out=7'b1111110 for 4 cycles.
2. Full frame walk with columns 7'h01,7'h02,7'h04,7'h08:
   - col_sel steps 1110, 1101, 1011, 0111, each for 4 cycles, separated by 2-cycle 1111 gaps.
   - frame_done pulses once at cycle 24 after the first BLANK.
   - Refresh repeats with identical data.
3. Second frame offered mid-frame-1: accepted into the shadow, frame_ready=0 until the boundary. Third frame offered: held off (ready low). Column 0 of the next frame shows the second frame.
4. enable deasserted during SHOW column 2:
   - Next cycle row_out=7'h7F, col_sel=4'hF, no frame_done.
   - Re-enable: BLANK 2 cycles, then column 0 of the same frame.
5. rst_n asserted asynchronously mid-SHOW (between edges):
   - Outputs go to all off immediately, frame_ready=1.
   - After release with no new frame: remains IDLE and dark.
6. Frame accepted in the exact cycle frame_done pulses with the shadow empty: the current active frame repeats once; the new frame is displayed from the following boundary.
